// File: rtl/dot_accum_stream.sv
// Streaming multi-beat dot product: registered lane products, pipelined adder tree,
// wrapping accumulator across a vector, saturated result under valid/ready handshakes.
module dot_accum_stream #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned LANES      = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned MAX_BEATS  = 9,
  localparam int unsigned CNT_WIDTH = $clog2(MAX_BEATS + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_signed,
  input  logic [CNT_WIDTH-1:0]        i_len,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [LANES*WORD_WIDTH-1:0] i_a,
  input  logic [LANES*WORD_WIDTH-1:0] i_b,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [OUT_WIDTH-1:0]        o_sum,
  output logic                        o_sat
);

  localparam int unsigned Lvls  = $clog2(LANES);
  localparam int unsigned TreeW = 2 * WORD_WIDTH + Lvls;
  localparam int unsigned Nodes = 2 * LANES;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StOut} state_e;

  state_e                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [CNT_WIDTH-1:0]   len_q, len_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [OUT_WIDTH-1:0]   sum_q, sum_d;
  logic                   sat_q, sat_d;
  logic [Lvls:0]          vld_q, vld_d;
  // Heap-ordered tree: leaves LANES..2*LANES-1 hold products, node n sums 2n and 2n+1.
  logic [TreeW-1:0]       node_q [1:Nodes-1];
  logic [TreeW-1:0]       node_d [1:Nodes-1];

  logic                    beat_fire, res_fire, prod_signed;
  logic signed [WORD_WIDTH:0] a_ext [LANES];
  logic signed [WORD_WIDTH:0] b_ext [LANES];
  logic signed [TreeW-1:0]    prod  [LANES];
  logic [ACC_WIDTH-1:0]       root_ext;
  logic [CNT_WIDTH-1:0]       len_eff;
  logic signed [ACC_WIDTH-1:0] acc_hi_s;
  logic [ACC_WIDTH-1:0]       acc_hi_u;
  logic                       clamp;
  logic [OUT_WIDTH-1:0]       clamp_val;

  assign o_ready   = i_rst_n && ((state_q == StIdle) || (state_q == StAccum));
  assign o_valid   = (state_q == StOut);
  assign o_sum     = sum_q;
  assign o_sat     = sat_q;
  assign beat_fire = i_valid && o_ready;
  assign res_fire  = o_valid && i_ready;

  // The first beat is multiplied in the same cycle the mode is latched.
  assign prod_signed = (state_q == StIdle) ? i_signed : mode_q;

  // Products are exact in TreeW bits, so the tree itself needs no sign handling.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      a_ext[k] = {prod_signed & i_a[k*WORD_WIDTH+WORD_WIDTH-1], i_a[k*WORD_WIDTH +: WORD_WIDTH]};
      b_ext[k] = {prod_signed & i_b[k*WORD_WIDTH+WORD_WIDTH-1], i_b[k*WORD_WIDTH +: WORD_WIDTH]};
      prod[k]  = TreeW'(a_ext[k]) * TreeW'(b_ext[k]);
    end
  end

  always_comb begin
    for (int n = 1; n < LANES; n++) begin
      node_d[n] = node_q[2*n] + node_q[2*n+1];
    end
    for (int k = 0; k < LANES; k++) begin
      node_d[LANES+k] = beat_fire ? prod[k] : node_q[LANES+k];
    end
  end

  assign vld_d    = {vld_q[Lvls-1:0], beat_fire};
  assign root_ext = mode_q ? ACC_WIDTH'($signed(node_q[1])) : ACC_WIDTH'(node_q[1]);

  always_comb begin
    acc_d = acc_q;
    if (res_fire) begin
      acc_d = '0;
    end else if (vld_q[Lvls]) begin
      acc_d = acc_q + root_ext;
    end
  end

  always_comb begin
    acc_hi_s = $signed(acc_q) >>> (OUT_WIDTH - 1);
    acc_hi_u = acc_q >> OUT_WIDTH;
    if (mode_q) begin
      clamp     = (acc_hi_s != '0) && (acc_hi_s != '1);
      clamp_val = acc_q[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                     : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else begin
      clamp     = (acc_hi_u != '0);
      clamp_val = '1;
    end
  end

  always_comb begin
    if (i_len == '0) begin
      len_eff = CNT_WIDTH'(1);
    end else if (i_len > CNT_WIDTH'(MAX_BEATS)) begin
      len_eff = CNT_WIDTH'(MAX_BEATS);
    end else begin
      len_eff = i_len;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    sat_d   = sat_q;
    case (state_q)
      StIdle: begin
        if (beat_fire) begin
          mode_d  = i_signed;
          len_d   = len_eff;
          cnt_d   = CNT_WIDTH'(1);
          state_d = (len_eff > CNT_WIDTH'(1)) ? StAccum : StDrain;
        end
      end
      StAccum: begin
        if (beat_fire) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q + CNT_WIDTH'(1) == len_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (vld_q == '0) begin
          sum_d   = clamp ? clamp_val : acc_q[OUT_WIDTH-1:0];
          sat_d   = clamp;
          state_d = StOut;
        end
      end
      StOut: begin
        if (i_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
      vld_q   <= '0;
      for (int n = 1; n < Nodes; n++) begin
        node_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
      vld_q   <= vld_d;
      for (int n = 1; n < Nodes; n++) begin
        node_q[n] <= node_d[n];
      end
    end
  end

endmodule
